// File: rtl/fp_add_pipe_if.sv
// Handshake/operand bundle for fp_add_pipe: producer side drives operands and
// out_ready, the adder drives in_ready, result and flags.
`timescale 1ns/1ps
interface fp_add_pipe_if #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [3:0]   flags;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, result, flags
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, result, flags
   );
endinterface

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: 3-stage floating-point adder/subtractor (unpack/align, add, normalise/round).
// Define FP_ADD_PIPE_RNE_EN for round-to-nearest-even; the default build truncates.
`timescale 1ns/1ps
module fp_add_pipe #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic         clk,
   input  logic         rst,
   fp_add_pipe_if.slave bus
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int MW = MAN_W + 4;
   localparam int SW = MAN_W + 5;
   localparam int XW = EXP_W + 2;
   localparam int LW = $clog2(MW + 1);
   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [XW-1:0]    ONE_X    = XW'(1);
   localparam logic [XW-1:0]    COLLAPSE = XW'(MAN_W + 3);
   localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

   function automatic logic [XW-1:0] eff_exp(input logic [EXP_W-1:0] e);
      return (e == '0) ? ONE_X : {2'b00, e};
   endfunction

   function automatic logic [MW-1:0] align_shift(input logic [MW-1:0] m, input logic [XW-1:0] d);
      logic [2*MW-1:0] ext;
      logic [MW-1:0]   res;
      ext = '0;
      if (d >= COLLAPSE) begin
         res = {{(MW-1){1'b0}}, |m};
      end else begin
         ext = {m, {MW{1'b0}}} >> d;
         res = ext[2*MW-1:MW];
         res[0] = res[0] | (|ext[MW-1:0]);
      end
      return res;
   endfunction

   function automatic logic [LW-1:0] lzc(input logic [MW-1:0] v);
      logic [LW-1:0] n;
      logic          found;
      n     = '0;
      found = 1'b0;
      for (int i = MW-1; i >= 0; i--) begin
         if (!found && v[i]) found = 1'b1;
         else if (!found)    n = n + 1'b1;
      end
      return n;
   endfunction

   // Returns {packed result, overflow, inexact}; m is {hidden, fraction, g, r, s}.
   function automatic logic [W+1:0] round_pack(input logic s, input logic [XW-1:0] e,
                                                 input logic [MW-1:0] m);
      logic [MAN_W+1:0] mr;
      logic [XW-1:0]    ef;
      logic [MAN_W-1:0] fr;
      logic             inc;
      logic             inx;
      inx = |m[2:0];
`ifdef FP_ADD_PIPE_RNE_EN
      inc = m[2] & (m[1] | m[0] | m[3]);
`else
      inc = 1'b0;
`endif
      mr = {1'b0, m[MW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
      if (mr[MAN_W+1]) begin
         ef = e + ONE_X;
         fr = mr[MAN_W:1];
      end else if (mr[MAN_W]) begin
         ef = e;
         fr = mr[MAN_W-1:0];
      end else begin
         ef = '0;
         fr = mr[MAN_W-1:0];
      end
      if (ef >= {2'b00, EXP_ONES})
         return {s, EXP_ONES, {MAN_W{1'b0}}, 1'b1, 1'b1};
      return {s, ef[EXP_W-1:0], fr, 1'b0, inx};
   endfunction

   logic                r_vld_p0, r_vld_p1, r_vld_p2;
   logic [W-1:0]        r_result_p2;
   logic [3:0]          r_flags_p2;
   logic                r_sign_p0, r_esub_p0, r_nan_p0, r_inf_p0;
   logic [XW-1:0]       r_exp_p0;
   logic [MW-1:0]       r_mbig_p0, r_msml_p0;
   logic                r_sign_p1, r_esub_p1, r_nan_p1, r_inf_p1;
   logic [XW-1:0]       r_exp_p1;
   logic signed [SW:0]  r_sum_p1;

   logic                w_adv;
   assign w_adv        = ~r_vld_p2 | bus.out_ready;
   assign bus.in_ready = w_adv;
   assign bus.out_valid = r_vld_p2;
   assign bus.result   = r_result_p2;
   assign bus.flags    = r_flags_p2;

   // ---- S1: unpack, order by magnitude, align the smaller operand
   logic             w_sa, w_sb;
   logic [EXP_W-1:0] w_ea, w_eb;
   logic [MAN_W-1:0] w_fa, w_fb;
   logic             w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_a_big, w_nan, w_inf;
   logic [XW-1:0]    w_xa, w_xb, w_diff;
   logic [MW-1:0]    w_ma, w_mb, w_msml;

   assign w_sa    = bus.a[W-1];
   assign w_ea    = bus.a[W-2 -: EXP_W];
   assign w_fa    = bus.a[MAN_W-1:0];
   assign w_sb    = bus.b[W-1] ^ bus.sub;
   assign w_eb    = bus.b[W-2 -: EXP_W];
   assign w_fb    = bus.b[MAN_W-1:0];
   assign w_nan_a = (w_ea == EXP_ONES) && (w_fa != '0);
   assign w_nan_b = (w_eb == EXP_ONES) && (w_fb != '0);
   assign w_inf_a = (w_ea == EXP_ONES) && (w_fa == '0);
   assign w_inf_b = (w_eb == EXP_ONES) && (w_fb == '0);
   assign w_nan   = w_nan_a | w_nan_b | (w_inf_a & w_inf_b & (w_sa ^ w_sb));
   assign w_inf   = w_inf_a | w_inf_b;
   // An infinity always wins the magnitude compare, so the big sign is the inf sign.
   assign w_a_big = {w_ea, w_fa} >= {w_eb, w_fb};
   assign w_xa    = eff_exp(w_ea);
   assign w_xb    = eff_exp(w_eb);
   assign w_ma    = {|w_ea, w_fa, 3'b000};
   assign w_mb    = {|w_eb, w_fb, 3'b000};
   assign w_diff  = w_a_big ? (w_xa - w_xb) : (w_xb - w_xa);
   assign w_msml  = align_shift(w_a_big ? w_mb : w_ma, w_diff);

   always_ff @(posedge clk) begin
      if (w_adv) begin
         r_sign_p0 <= w_a_big ? w_sa : w_sb;
         r_exp_p0  <= w_a_big ? w_xa : w_xb;
         r_mbig_p0 <= w_a_big ? w_ma : w_mb;
         r_msml_p0 <= w_msml;
         r_esub_p0 <= w_sa ^ w_sb;
         r_nan_p0  <= w_nan;
         r_inf_p0  <= w_inf & ~w_nan;
      end
   end

   // ---- S2: signed mantissa add/subtract (big >= small, so the sum is non-negative)
   logic signed [SW:0] w_big_s, w_sml_s, w_sum_s;
   assign w_big_s = $signed({2'b00, r_mbig_p0});
   assign w_sml_s = $signed({2'b00, r_msml_p0});
   assign w_sum_s = r_esub_p0 ? (w_big_s - w_sml_s) : (w_big_s + w_sml_s);

   always_ff @(posedge clk) begin
      if (w_adv) begin
         r_sum_p1  <= w_sum_s;
         r_sign_p1 <= r_sign_p0;
         r_exp_p1  <= r_exp_p0;
         r_esub_p1 <= r_esub_p0;
         r_nan_p1  <= r_nan_p0;
         r_inf_p1  <= r_inf_p0;
      end
   end

   // ---- S3: normalise (left shift clamped at exponent 1), round, pack, specials
   logic [SW-1:0] w_mag;
   logic [LW-1:0] w_lz;
   logic [XW-1:0] w_lzx, w_maxsh, w_sh, w_nexp;
   logic [MW-1:0] w_norm;
   logic [W+1:0]  w_rp;
   logic [W-1:0]  w_res;
   logic [3:0]    w_flags;

   assign w_mag   = r_sum_p1[SW-1:0];
   assign w_lz    = lzc(w_mag[MW-1:0]);
   assign w_lzx   = XW'(w_lz);
   assign w_maxsh = r_exp_p1 - ONE_X;
   assign w_sh    = (w_lzx < w_maxsh) ? w_lzx : w_maxsh;

   always_comb begin
      w_norm = w_mag[MW-1:0] << w_sh;
      w_nexp = r_exp_p1 - w_sh;
      if (w_mag[SW-1]) begin
         w_norm = {w_mag[SW-1:2], w_mag[1] | w_mag[0]};
         w_nexp = r_exp_p1 + ONE_X;
      end
   end

   assign w_rp = round_pack(r_sign_p1, w_nexp, w_norm);

   always_comb begin
      w_res   = w_rp[W+1:2];
      w_flags = {1'b0, w_rp[1], 1'b0, w_rp[0]};
      if (r_nan_p1) begin
         w_res   = QNAN;
         w_flags = 4'b1000;
      end else if (r_inf_p1) begin
         w_res   = {r_sign_p1, EXP_ONES, {MAN_W{1'b0}}};
         w_flags = 4'b0000;
      end else if (r_sum_p1 == '0) begin
         w_res   = {r_sign_p1 & ~r_esub_p1, {(W-1){1'b0}}};
         w_flags = 4'b0010;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld_p0    <= 1'b0;
         r_vld_p1    <= 1'b0;
         r_vld_p2    <= 1'b0;
         r_result_p2 <= '0;
         r_flags_p2  <= '0;
      end else if (w_adv) begin
         r_vld_p0    <= bus.in_valid;
         r_vld_p1    <= r_vld_p0;
         r_vld_p2    <= r_vld_p1;
         r_result_p2 <= w_res;
         r_flags_p2  <= w_flags;
      end
   end
endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed bench for fp_add_pipe (half precision): specials, rounding, backpressure, reset.
`timescale 1ns/1ps
module tb_fp_add_pipe;
   localparam int EXP_W = 5;
   localparam int MAN_W = 10;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   fp_add_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

   fp_add_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s: observed %h required %h", tag, obs, req);
      end
   endtask

   // Issue one op into an idle pipe, check latency, result, flags and that it is not repeated.
   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [15:0] er, input logic [3:0] ef);
      int n;
      bus.a = a; bus.b = b; bus.sub = s; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, " latency"}, 32'(n), 32'd2);
      chk({tag, " result"},  32'(bus.result), 32'(er));
      chk({tag, " flags"},   32'(bus.flags),  32'(ef));
      @(posedge clk); #1;
      chk({tag, " single"},  32'(bus.out_valid), 32'd0);
   endtask

   logic [15:0] st_a [6];
   logic [15:0] st_b [6];
   logic [15:0] st_r [6];
   int          sent, got, stale;
   logic        acc;

   initial begin
      st_a = '{16'h3C00, 16'h3C00, 16'h4000, 16'h4400, 16'h4400, 16'h4400};
      st_b = '{16'h3C00, 16'h4000, 16'h4000, 16'h3C00, 16'h4000, 16'h4200};
      st_r = '{16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700};

      rst = 1'b1; bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.out_ready = 1'b1;
      #12;
      chk("reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset in_ready",  32'(bus.in_ready),  32'd1);
      chk("reset result",    32'(bus.result),    32'd0);
      chk("reset flags",     32'(bus.flags),     32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_op("1+2",        16'h3C00, 16'h4000, 1'b0, 16'h4200, 4'b0000);
      run_op("max+max",    16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101);
      run_op("inf-inf",    16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 4'b1000);
      run_op("1-1",        16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0010);
      run_op("sub+sub",    16'h0001, 16'h0001, 1'b0, 16'h0002, 4'b0000);
`ifdef FP_ADD_PIPE_RNE_EN
      run_op("round odd",  16'h3C01, 16'h1000, 1'b0, 16'h3C02, 4'b0001);
`else
      run_op("round odd",  16'h3C01, 16'h1000, 1'b0, 16'h3C01, 4'b0001);
`endif
      run_op("round even", 16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'b0001);
      run_op("-0+-0",      16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b0010);
      run_op("nan in",     16'h7C01, 16'h3C00, 1'b0, 16'h7E00, 4'b1000);
      run_op("inf+1",      16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 4'b0000);
      run_op("inf sub inf",16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 4'b1000);
      run_op("1-2",        16'h3C00, 16'h4000, 1'b1, 16'hBC00, 4'b0000);
      run_op("gradual uf", 16'h0400, 16'h03FF, 1'b1, 16'h0001, 4'b0000);

      // Six ops back-to-back with the consumer stalled during cycles 4..8.
      sent = 0; got = 0;
      for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
         bus.out_ready = (cyc < 4 || cyc > 8);
         bus.in_valid  = (sent < 6);
         bus.a         = st_a[(sent < 6) ? sent : 5];
         bus.b         = st_b[(sent < 6) ? sent : 5];
         bus.sub       = 1'b0;
         #4;
         acc = bus.in_valid & bus.in_ready;
         if (!bus.out_ready) begin
            chk($sformatf("stall%0d in_ready", cyc),  32'(bus.in_ready),  32'd0);
            chk($sformatf("stall%0d out_valid", cyc), 32'(bus.out_valid), 32'd1);
            chk($sformatf("stall%0d result", cyc),    32'(bus.result),    32'(st_r[got]));
         end else if (bus.out_valid) begin
            chk($sformatf("stream%0d result", got), 32'(bus.result), 32'(st_r[got]));
            chk($sformatf("stream%0d flags", got),  32'(bus.flags),  32'd0);
            got++;
         end
         @(posedge clk); #1;
         if (acc) sent++;
      end
      chk("stream delivered", 32'(got), 32'd6);
      chk("stream drained",   32'(bus.out_valid), 32'd0);

      // Reset with two ops in flight: one at the output, one inside the pipe.
      bus.out_ready = 1'b1;
      bus.a = 16'h3C00; bus.b = 16'h3C00; bus.sub = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.a = 16'h4000; bus.b = 16'h4000;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("pre-reset out_valid", 32'(bus.out_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("async rst in_ready",  32'(bus.in_ready),  32'd1);
      chk("async rst result",    32'(bus.result),    32'd0);
      chk("async rst flags",     32'(bus.flags),     32'd0);
      @(posedge clk); #3;
      rst = 1'b0;
      stale = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) stale++;
      end
      chk("no stale after rst", 32'(stale), 32'd0);
      run_op("post-rst 3+1", 16'h4200, 16'h3C00, 1'b0, 16'h4400, 4'b0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
